// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART/sync-serial clock generators.
// Holds state encodings, accumulator widths and the pin-clock phase rule.
package uart_pkg;

    localparam int ACC_W  = 16;
    localparam int FREQ_W = 12;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // Pin clock level for an oversample slot; cnt MSB splits the bit in halves
    function automatic logic phase(
        input logic             cpol,
        input logic             cpha,
        input logic [CNT_W-1:0] cnt
    );
        return cpol ^ cpha ^ cnt[CNT_W-1];
    endfunction

endpackage

// File: rtl/uart_baud_acc.sv
// Fractional baud accumulator producing the 16x oversample enable.
// Shared by the transmit and receive clock generators.
module uart_baud_acc
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [FREQ_W-1:0] baud_freq,
    input  logic [ACC_W-1:0]  baud_limit,
    output logic              ce_16
);

    logic [ACC_W-1:0] counter_q;
    logic [ACC_W-1:0] counter_d;
    logic             ce_16_q;
    logic             ce_16_d;

    // Wrap on threshold and flag the enable, otherwise add the increment
    always_comb begin
        counter_d = counter_q;
        ce_16_d   = 1'b0;
        if (clr) begin
            counter_d = '0;
        end else if (counter_q >= baud_limit) begin
            counter_d = counter_q - baud_limit;
            ce_16_d   = 1'b1;
        end else begin
            counter_d = counter_q + {{(ACC_W-FREQ_W){1'b0}}, baud_freq};
        end
    end

    // Accumulator and enable registers
    always_ff @(posedge clk) begin
        if (clr) begin
            counter_q <= '0;
            ce_16_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            ce_16_q   <= ce_16_d;
        end
    end

    assign ce_16 = ce_16_q;

endmodule

// File: rtl/uart_tx_clk_gen.sv
// Transmit-side timing generator: bit-launch strobes and sync serial clock.
// One bit period is sixteen oversample enables from the baud accumulator.
module uart_tx_clk_gen
    import uart_pkg::*;
#(
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [FREQ_W-1:0] baud_freq,
    input  logic [ACC_W-1:0]  baud_limit,
    input  logic              sync_mode,
    input  logic              tx_active,
    output logic              bit_start,
    output logic              busy,
    output logic              sync_clk_out,
    output logic              sync_clk_oe
);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [CNT_W-1:0] count16_q;
    logic [CNT_W-1:0] count16_d;
    logic             bit_start_q;
    logic             bit_start_d;
    logic             busy_q;
    logic             busy_d;
    logic             sync_clk_q;
    logic             sync_clk_d;
    logic             sync_oe_q;
    logic             sync_oe_d;

    logic             r_cond;
    logic             ce_16;
    logic             be;
    logic             go_idle;
    logic             acc_clr;

    assign r_cond  = rst | ~en;
    assign be      = (state_q == ST_RUN) & ce_16 & (count16_q == 4'hF);
    assign go_idle = be & ~tx_active;
    assign acc_clr = r_cond | (state_q != ST_RUN) | go_idle;

    uart_baud_acc u_acc (
        .clk        (clk),
        .clr        (acc_clr),
        .baud_freq  (baud_freq),
        .baud_limit (baud_limit),
        .ce_16      (ce_16)
    );

    // Next state, bit launch and pin clock level
    always_comb begin
        state_d     = state_q;
        count16_d   = count16_q;
        bit_start_d = 1'b0;
        sync_clk_d  = sync_clk_q;
        sync_oe_d   = sync_mode;
        unique case (state_q)
            ST_IDLE: begin
                count16_d  = '0;
                sync_clk_d = CPOL;
                if (tx_active) begin
                    state_d     = ST_RUN;
                    bit_start_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ce_16) begin
                    count16_d  = count16_q + 4'd1;
                    sync_clk_d = phase(CPOL, CPHA, count16_q);
                end
                if (!sync_mode) begin
                    sync_clk_d = CPOL;
                end
                if (be) begin
                    if (tx_active) begin
                        bit_start_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        count16_d  = '0;
                        sync_clk_d = CPOL;
                    end
                end
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // FSM and registered outputs; disable behaves like reset
    always_ff @(posedge clk) begin
        if (r_cond) begin
            state_q     <= ST_IDLE;
            count16_q   <= '0;
            bit_start_q <= 1'b0;
            busy_q      <= 1'b0;
            sync_clk_q  <= CPOL;
            sync_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count16_q   <= count16_d;
            bit_start_q <= bit_start_d;
            busy_q      <= busy_d;
            sync_clk_q  <= sync_clk_d;
            sync_oe_q   <= sync_oe_d;
        end
    end

    assign bit_start    = bit_start_q;
    assign busy         = busy_q;
    assign sync_clk_out = sync_clk_q;
    assign sync_clk_oe  = sync_oe_q;

endmodule

// File: tb/tb_uart_tx_clk_gen.sv
// Scoreboard bench for uart_tx_clk_gen across all four CPOL/CPHA builds.
// A frame-level model predicts strobes, busy, pin clock and output enable.
module tb_uart_tx_clk_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] baud_freq;
    logic [15:0] baud_limit;
    logic        sync_mode;
    logic        tx_active;
    logic [3:0]  bs;
    logic [3:0]  busy;
    logic [3:0]  sck;
    logic [3:0]  oe;

    typedef struct {
        int       cyc;
        logic [3:0] bs;
        logic [3:0] busy;
        logic [3:0] sck;
        logic [3:0] oe;
    } exp_t;

    exp_t exp_q[$];
    int   bs_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_clk_gen #(.CPOL(1'b0), .CPHA(1'b0)) u00 (
        .clk(clk), .rst(rst), .en(en), .baud_freq(baud_freq),
        .baud_limit(baud_limit), .sync_mode(sync_mode), .tx_active(tx_active),
        .bit_start(bs[0]), .busy(busy[0]), .sync_clk_out(sck[0]),
        .sync_clk_oe(oe[0]));
    uart_tx_clk_gen #(.CPOL(1'b0), .CPHA(1'b1)) u01 (
        .clk(clk), .rst(rst), .en(en), .baud_freq(baud_freq),
        .baud_limit(baud_limit), .sync_mode(sync_mode), .tx_active(tx_active),
        .bit_start(bs[1]), .busy(busy[1]), .sync_clk_out(sck[1]),
        .sync_clk_oe(oe[1]));
    uart_tx_clk_gen #(.CPOL(1'b1), .CPHA(1'b0)) u10 (
        .clk(clk), .rst(rst), .en(en), .baud_freq(baud_freq),
        .baud_limit(baud_limit), .sync_mode(sync_mode), .tx_active(tx_active),
        .bit_start(bs[2]), .busy(busy[2]), .sync_clk_out(sck[2]),
        .sync_clk_oe(oe[2]));
    uart_tx_clk_gen #(.CPOL(1'b1), .CPHA(1'b1)) u11 (
        .clk(clk), .rst(rst), .en(en), .baud_freq(baud_freq),
        .baud_limit(baud_limit), .sync_mode(sync_mode), .tx_active(tx_active),
        .bit_start(bs[3]), .busy(busy[3]), .sync_clk_out(sck[3]),
        .sync_clk_oe(oe[3]));

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, req);
        end
    endtask

    // Pin level in slot idx of a bit: the sample edge lands at the half-bit
    function automatic logic ph(input logic cpol, input logic cpha, input int idx);
        logic second_half;
        second_half = (idx >= 8);
        if (!cpha) return second_half ? ~cpol : cpol;
        return second_half ? cpol : ~cpol;
    endfunction

    // Monitor: strobe events against the event queue, levels per cycle
    always @(negedge clk) begin
        exp_t r;
        int   e;
        if (bs[0]) begin
            n_cmp++;
            if (bs_q.size() == 0) begin
                n_bad++;
                $display("FAIL bit_start_evt cyc=%0d actual=pulse required=none", cyc);
            end else begin
                e = bs_q.pop_front();
                if (e != cyc) begin
                    n_bad++;
                    $display("FAIL bit_start_evt actual_cyc=%0d required_cyc=%0d", cyc, e);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_check actual_cyc=%0d required_cyc=%0d", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            r = exp_q.pop_front();
            chk("bit_start", bs, r.bs);
            chk("busy", busy, r.busy);
            chk("sync_clk_out", sck, r.sck);
            chk("sync_clk_oe", oe, r.oe);
        end
    end

    function automatic bit is_be(input int q[$], input int n, input int k);
        for (int m = 0; m < n; m++) if (q[m] == k) return 1'b1;
        return 1'b0;
    endfunction

    // One frame of nbits; abort_ce >= 0 aborts at that oversample enable
    task automatic run_frame(input int f, input int l, input logic sm,
                             input int nbits, input int abort_ce, input bit by_en);
        int   ce_k[$];
        int   be_k[$];
        int   c, k, p, kend, abort_k, drop_k, jn, last;
        exp_t r;
        @(negedge clk);
        baud_freq  = 12'(f);
        baud_limit = 16'(l);
        sync_mode  = sm;
        tx_active  = 1'b0;
        rst        = 1'b0;
        en         = 1'b1;
        repeat (2) @(negedge clk);
        c = 0;
        k = 0;
        while (ce_k.size() < 16 * nbits) begin
            if (c >= l) begin
                c = c - l;
                ce_k.push_back(k + 1);
            end else begin
                c = c + f;
            end
            k++;
        end
        for (int m = 1; m <= nbits; m++) be_k.push_back(ce_k[16*m-1]);
        abort_k = (abort_ce >= 0) ? ce_k[abort_ce] : -1;
        kend    = (abort_k >= 0) ? abort_k + 1 : be_k[nbits-1] + 1;
        drop_k  = ce_k[16*(nbits-1)+8];
        p       = cyc + 1;
        jn      = 0;
        for (k = 0; k <= kend + 2; k++) begin
            r.cyc = p + k;
            r.bs  = (k == 0) ? 4'hF : 4'h0;
            for (int m = 0; m < nbits - 1; m++)
                if (be_k[m] + 1 == k && k < kend) r.bs = 4'hF;
            r.busy = (k < kend) ? 4'hF : 4'h0;
            while (jn < ce_k.size() && ce_k[jn] < k) jn++;
            last = jn - 1;
            for (int i = 0; i < 4; i++) begin
                logic cp, ch;
                cp = i[1];
                ch = i[0];
                if (!sm || k >= kend || last < 0) r.sck[i] = cp;
                else r.sck[i] = ph(cp, ch, last % 16);
            end
            r.oe = (abort_k >= 0 && k == kend) ? 4'h0 : {4{sm}};
            if (r.bs[0]) bs_q.push_back(p + k);
            exp_q.push_back(r);
        end
        tx_active = 1'b1;
        for (k = 0; k <= kend + 1; k++) begin
            @(negedge clk);
            rst = 1'b0;
            en  = 1'b1;
            if (k == abort_k) begin
                if (by_en) en = 1'b0;
                else rst = 1'b1;
            end
            if (abort_k >= 0 && k >= abort_k) tx_active = 1'b0;
            else if (is_be(be_k, nbits - 1, k)) tx_active = 1'b1;
            else if (k >= drop_k) tx_active = 1'b0;
            else tx_active = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        exp_t r;
        int   l, f, nb, ab;
        bit   be_n;
        rst        = 1'b1;
        en         = 1'b1;
        tx_active  = 1'b0;
        sync_mode  = 1'b1;
        baud_freq  = '0;
        baud_limit = '0;
        repeat (3) @(negedge clk);
        r.cyc  = cyc + 1;
        r.bs   = 4'h0;
        r.busy = 4'h0;
        r.sck  = 4'b1100;
        r.oe   = 4'h0;
        exp_q.push_back(r);
        @(negedge clk);
        rst = 1'b0;

        run_frame(1, 1, 1'b1, 4, -1, 1'b0);
        run_frame(3, 5, 1'b1, 2, -1, 1'b0);
        run_frame(1, 1, 1'b0, 3, -1, 1'b0);
        run_frame(1, 1, 1'b1, 3, 25, 1'b0);
        run_frame(1, 1, 1'b1, 2, -1, 1'b0);
        run_frame(0, 0, 1'b1, 3, -1, 1'b0);
        run_frame(0, 0, 1'b1, 3, 25, 1'b1);

        for (int t = 0; t < 6; t++) begin
            l  = $urandom_range(0, 12);
            f  = (l == 0) ? 0 : $urandom_range(1, l);
            nb = $urandom_range(1, 3);
            ab = -1;
            if ($urandom_range(0, 2) == 0) begin
                do ab = $urandom_range(1, 16 * nb - 2);
                while (ab % 16 == 15);
            end
            be_n = 1'($urandom_range(0, 1));
            run_frame(f, l, 1'($urandom_range(0, 1)), nb, ab, be_n);
        end

        repeat (4) @(negedge clk);
        n_cmp++;
        if (bs_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d/%0d pending required=0/0",
                     bs_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
